ctrl_pipe_chain: RTL and testbench

//   Parametrised chain of control-word pipeline registers: the successor to the fixed
//   ID/EX, EX/MEM and MEM/WB control registers and the NOP control mux.

---
 rtl/ctrl_pipe_chain.sv | 130 +++++++++++++
 tb/tb_ctrl_pipe_chain.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_chain.sv
// Parametrised chain of control-word pipeline registers with per-stage stall, flush and
// bubble insertion. Optional perf counters are enabled with the PIPE_PERF_EN macro.
module ctrl_pipe_chain #(
  parameter int unsigned      WIDTH     = 14,
  parameter int unsigned      DEPTH     = 3,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
  input  logic                       Clk,
  input  logic                       R,
  input  logic [WIDTH-1:0]           D,
  input  logic                       D_valid,
  output logic                       D_ready,
  input  logic                       stall_en,
  input  logic [$clog2(DEPTH)-1:0]   stall_stage,
  input  logic [DEPTH-1:0]           flush,
  output logic [DEPTH*WIDTH-1:0]     stage_word,
  output logic [DEPTH-1:0]           stage_valid,
  output logic [WIDTH-1:0]           Q,
  output logic                       Q_valid,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [15:0]                stall_cnt,
  output logic [15:0]                bubble_cnt
);

  localparam int unsigned SW = $clog2(DEPTH);
  localparam int unsigned OW = $clog2(DEPTH + 1);
  localparam logic [SW:0] LastStage = (SW+1)'(DEPTH - 1);

  logic [WIDTH-1:0] word_q   [DEPTH];
  logic [WIDTH-1:0] word_d   [DEPTH];
  logic [WIDTH-1:0] prev_word[DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d, prev_valid;
  logic [DEPTH-1:0] hold_vec, bubble_vec;
  logic [OW-1:0]    occ_q, occ_d;
  logic [SW:0]      stall_ext;

  // One extra bit so stall_stage+1 never wraps onto stage 0.
  assign stall_ext = {1'b0, stall_stage};

  always_comb begin
    prev_word[0]  = D;
    prev_valid[0] = D_valid;
    for (int k = 1; k < DEPTH; k++) begin
      prev_word[k]  = word_q[k-1];
      prev_valid[k] = valid_q[k-1];
    end
  end

  always_comb begin
    hold_vec   = '0;
    bubble_vec = '0;
    for (int k = 0; k < DEPTH; k++) begin
      hold_vec[k]   = stall_en && ((SW+1)'(k) <= stall_ext);
      bubble_vec[k] = stall_en && ((SW+1)'(k) == stall_ext + (SW+1)'(1));
    end
  end

  // Priority: flush > hold > bubble > advance (reset handled in the register).
  always_comb begin
    valid_d = '0;
    occ_d   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      word_d[k] = NOP_VALUE;
      if (flush[k]) begin
        word_d[k]  = NOP_VALUE;
        valid_d[k] = 1'b0;
      end else if (hold_vec[k]) begin
        word_d[k]  = word_q[k];
        valid_d[k] = valid_q[k];
      end else if (bubble_vec[k]) begin
        word_d[k]  = NOP_VALUE;
        valid_d[k] = 1'b0;
      end else begin
        word_d[k]  = prev_word[k];
        valid_d[k] = prev_valid[k];
      end
      occ_d = occ_d + OW'(valid_d[k]);
    end
  end

  always_ff @(posedge Clk) begin
    if (R) begin
      for (int k = 0; k < DEPTH; k++) word_q[k] <= NOP_VALUE;
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) word_q[k] <= word_d[k];
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  always_comb begin
    stage_word = '0;
    for (int k = 0; k < DEPTH; k++) stage_word[k*WIDTH +: WIDTH] = word_q[k];
  end

  assign stage_valid = valid_q;
  assign Q           = word_q[DEPTH-1];
  assign Q_valid     = valid_q[DEPTH-1];
  assign occupancy   = occ_q;
  assign D_ready     = ~stall_en | R;

`ifdef PIPE_PERF_EN
  logic [15:0] stall_cnt_q, bubble_cnt_q;
  logic        bubble_evt;

  // A bubble exists only when the stall point leaves a stage below it.
  assign bubble_evt = (|(flush & valid_q)) || (stall_en && (stall_ext < LastStage));

  always_ff @(posedge Clk) begin
    if (R) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (stall_en && (stall_cnt_q != 16'hFFFF))    stall_cnt_q  <= stall_cnt_q + 16'd1;
      if (bubble_evt && (bubble_cnt_q != 16'hFFFF)) bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  logic unused_last;
  assign unused_last = ^LastStage;
  assign stall_cnt   = 16'h0000;
  assign bubble_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Table-driven bench for ctrl_pipe_chain (WIDTH=14, DEPTH=3, NOP_VALUE=0), plus
// hand-written counter sequences when PIPE_PERF_EN is defined.
module tb_ctrl_pipe_chain;

  logic        Clk = 1'b0;
  logic        R = 1'b0;
  logic [13:0] D = '0;
  logic        D_valid = 1'b0;
  logic        D_ready;
  logic        stall_en = 1'b0;
  logic [1:0]  stall_stage = '0;
  logic [2:0]  flush = '0;
  logic [41:0] stage_word;
  logic [2:0]  stage_valid;
  logic [13:0] Q;
  logic        Q_valid;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt, bubble_cnt;

  int checks = 0;
  int errors = 0;

  ctrl_pipe_chain #(.WIDTH(14), .DEPTH(3), .NOP_VALUE(14'h0)) dut (
    .Clk(Clk), .R(R), .D(D), .D_valid(D_valid), .D_ready(D_ready),
    .stall_en(stall_en), .stall_stage(stall_stage), .flush(flush),
    .stage_word(stage_word), .stage_valid(stage_valid), .Q(Q), .Q_valid(Q_valid),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        r;
    logic [13:0] d;
    logic        dv;
    logic        se;
    logic [1:0]  ss;
    logic [2:0]  fl;
    logic [13:0] e0, e1, e2;
    logic [2:0]  ev;
    logic [1:0]  eocc;
    logic        erdy;
  } vec_t;

  localparam int NV = 29;
  vec_t tv [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    //        r  d        dv se ss fl     s0       s1       s2       v       occ  rdy
    tv[0]  = '{1, 14'h3FFF, 1, 0, 0, 3'b000, 14'h0,    14'h0,    14'h0,    3'b000, 2'd0, 1};
    tv[1]  = '{0, 14'h3FFF, 1, 0, 0, 3'b000, 14'h3FFF, 14'h0,    14'h0,    3'b001, 2'd1, 1};
    tv[2]  = '{0, 14'h1,    1, 0, 0, 3'b000, 14'h1,    14'h3FFF, 14'h0,    3'b011, 2'd2, 1};
    tv[3]  = '{0, 14'h2,    1, 0, 0, 3'b000, 14'h2,    14'h1,    14'h3FFF, 3'b111, 2'd3, 1};
    tv[4]  = '{0, 14'h3,    1, 0, 0, 3'b000, 14'h3,    14'h2,    14'h1,    3'b111, 2'd3, 1};
    tv[5]  = '{0, 14'h4,    1, 0, 0, 3'b000, 14'h4,    14'h3,    14'h2,    3'b111, 2'd3, 1};
    tv[6]  = '{0, 14'h5,    1, 0, 0, 3'b000, 14'h5,    14'h4,    14'h3,    3'b111, 2'd3, 1};
    tv[7]  = '{0, 14'h6,    1, 0, 0, 3'b000, 14'h6,    14'h5,    14'h4,    3'b111, 2'd3, 1};
    tv[8]  = '{0, 14'h7,    1, 0, 0, 3'b000, 14'h7,    14'h6,    14'h5,    3'b111, 2'd3, 1};
    // stall at stage 0: stage 1 takes bubbles, stage 2 drains
    tv[9]  = '{0, 14'h8,    1, 1, 0, 3'b000, 14'h7,    14'h0,    14'h6,    3'b101, 2'd2, 0};
    tv[10] = '{0, 14'h8,    1, 1, 0, 3'b000, 14'h7,    14'h0,    14'h0,    3'b001, 2'd1, 0};
    tv[11] = '{0, 14'h8,    1, 0, 0, 3'b000, 14'h8,    14'h7,    14'h0,    3'b011, 2'd2, 1};
    tv[12] = '{0, 14'hA,    1, 0, 0, 3'b000, 14'hA,    14'h8,    14'h7,    3'b111, 2'd3, 1};
    tv[13] = '{0, 14'hB,    1, 0, 0, 3'b000, 14'hB,    14'hA,    14'h8,    3'b111, 2'd3, 1};
    tv[14] = '{0, 14'hC,    1, 0, 0, 3'b000, 14'hC,    14'hB,    14'hA,    3'b111, 2'd3, 1};
    // flush beats hold on stages 0,1; stage 2 sits at stall_stage+1 so it bubbles
    tv[15] = '{0, 14'hD,    1, 1, 1, 3'b011, 14'h0,    14'h0,    14'h0,    3'b000, 2'd0, 0};
    tv[16] = '{0, 14'h1,    1, 0, 0, 3'b000, 14'h1,    14'h0,    14'h0,    3'b001, 2'd1, 1};
    tv[17] = '{0, 14'h2,    1, 0, 0, 3'b000, 14'h2,    14'h1,    14'h0,    3'b011, 2'd2, 1};
    tv[18] = '{0, 14'h3,    1, 0, 0, 3'b000, 14'h3,    14'h2,    14'h1,    3'b111, 2'd3, 1};
    // full hold with flush 011: stage 2 keeps its word
    tv[19] = '{0, 14'h4,    1, 1, 2, 3'b011, 14'h0,    14'h0,    14'h1,    3'b100, 2'd1, 0};
    tv[20] = '{0, 14'h5,    1, 0, 0, 3'b000, 14'h5,    14'h0,    14'h0,    3'b001, 2'd1, 1};
    tv[21] = '{0, 14'h6,    1, 0, 0, 3'b000, 14'h6,    14'h5,    14'h0,    3'b011, 2'd2, 1};
    tv[22] = '{0, 14'h7,    1, 1, 2, 3'b000, 14'h6,    14'h5,    14'h0,    3'b011, 2'd2, 0};
    tv[23] = '{0, 14'h7,    1, 1, 3, 3'b000, 14'h6,    14'h5,    14'h0,    3'b011, 2'd2, 0};
    tv[24] = '{1, 14'h7,    1, 1, 2, 3'b011, 14'h0,    14'h0,    14'h0,    3'b000, 2'd0, 1};
    tv[25] = '{0, 14'h9,    1, 1, 0, 3'b000, 14'h0,    14'h0,    14'h0,    3'b000, 2'd0, 0};
    tv[26] = '{0, 14'h1,    1, 0, 0, 3'b000, 14'h1,    14'h0,    14'h0,    3'b001, 2'd1, 1};
    tv[27] = '{0, 14'h2,    1, 0, 0, 3'b001, 14'h0,    14'h1,    14'h0,    3'b010, 2'd1, 1};
    // invalid word is still captured
    tv[28] = '{0, 14'h55,   0, 0, 0, 3'b000, 14'h55,   14'h0,    14'h1,    3'b100, 2'd1, 1};

    tick();
    for (int i = 0; i < NV; i++) begin
      R = tv[i].r; D = tv[i].d; D_valid = tv[i].dv;
      stall_en = tv[i].se; stall_stage = tv[i].ss; flush = tv[i].fl;
      #1;
      chk($sformatf("v%0d D_ready", i), 32'(D_ready), 32'(tv[i].erdy));
      tick();
      chk($sformatf("v%0d stage0", i), 32'(stage_word[0 +: 14]), 32'(tv[i].e0));
      chk($sformatf("v%0d stage1", i), 32'(stage_word[14 +: 14]), 32'(tv[i].e1));
      chk($sformatf("v%0d stage2", i), 32'(stage_word[28 +: 14]), 32'(tv[i].e2));
      chk($sformatf("v%0d valid", i), 32'(stage_valid), 32'(tv[i].ev));
      chk($sformatf("v%0d occupancy", i), 32'(occupancy), 32'(tv[i].eocc));
      chk($sformatf("v%0d Q", i), 32'(Q), 32'(tv[i].e2));
      chk($sformatf("v%0d Q_valid", i), 32'(Q_valid), 32'(tv[i].ev[2]));
    end

    R = 1'b1; stall_en = 1'b0; flush = '0; D_valid = 1'b0;
    tick();
    R = 1'b0;

`ifdef PIPE_PERF_EN
    chk("perf reset stall_cnt", 32'(stall_cnt), 32'h0);
    chk("perf reset bubble_cnt", 32'(bubble_cnt), 32'h0);
    stall_en = 1'b1; stall_stage = 2'd2;
    repeat (3) tick();
    stall_en = 1'b0;
    tick();
    chk("perf stall_cnt 3", 32'(stall_cnt), 32'd3);
    chk("perf no bubble on full hold", 32'(bubble_cnt), 32'd0);
    D = 14'h11; D_valid = 1'b1;
    tick();
    D_valid = 1'b0; flush = 3'b001;
    tick();
    flush = 3'b000;
    chk("perf flush kill", 32'(bubble_cnt), 32'd1);
    flush = 3'b001;
    tick();
    flush = 3'b000;
    chk("perf flush of empty stage", 32'(bubble_cnt), 32'd1);
    stall_en = 1'b1; stall_stage = 2'd0;
    tick();
    stall_en = 1'b0;
    chk("perf bubble insert", 32'(bubble_cnt), 32'd2);
    stall_en = 1'b1; stall_stage = 2'd2;
    repeat (70000) tick();
    stall_en = 1'b0;
    chk("perf stall_cnt saturate", 32'(stall_cnt), 32'hFFFF);
    R = 1'b1;
    tick();
    R = 1'b0;
    chk("perf reset clears stall_cnt", 32'(stall_cnt), 32'h0);
`else
    stall_en = 1'b1; stall_stage = 2'd0; flush = 3'b111;
    repeat (4) tick();
    stall_en = 1'b0; flush = '0;
    chk("stall_cnt tied", 32'(stall_cnt), 32'h0);
    chk("bubble_cnt tied", 32'(bubble_cnt), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
